encoder_priority_rr_n: RTL

//  Parametrised N-to-log2(N) priority encoder with a registered, handshaked output.
//  Two priority modes:
//   - Fixed: MSB wins.
//   - Round-robin: rotating priority, so no request line can starve.

---
 rtl/encoder_priority_rr_n.sv | 79 +++++++
 1 files changed

// File: rtl/encoder_priority_rr_n.sv
// N-to-log2(N) priority encoder, fixed (MSB wins) or round-robin priority,
// with a 1-deep registered result behind a valid/ready handshake.
module encoder_priority_rr_n #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         rr_en,
    output logic [W-1:0] d_out,
    output logic         invalid_input,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] ptr;
    logic [W-1:0] fixed_idx;
    logic [W-1:0] low_idx;
    logic         low_hit;
    logic [W-1:0] win_idx;
    logic         any_req;
    logic         accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign any_req  = |d_in;

    // Round-robin search ptr, ptr-1, ..., 0 first; if nothing is set at or
    // below ptr the search wraps to N-1 downward, which is the plain MSB pick.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        fixed_idx = '0;
        low_idx   = '0;
        low_hit   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (d_in[i]) begin
                fixed_idx = W'(i);
                if (W'(i) <= ptr) begin
                    low_idx = W'(i);
                    low_hit = 1'b1;
                end
            end
        end
    end

    assign win_idx = (rr_en && low_hit) ? low_idx : fixed_idx;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            out_valid     <= 1'b0;
            d_out         <= '0;
            invalid_input <= 1'b0;
            ptr           <= LAST;
        end else if (accept) begin
            out_valid <= 1'b1;
            if (!any_req) begin
                invalid_input <= 1'b1;
                d_out         <= '0;
            end else begin
                invalid_input <= 1'b0;
                d_out         <= win_idx;
                // The winner drops to lowest priority; fixed mode re-arms at N-1.
                if (rr_en)
                    ptr <= (win_idx == '0) ? LAST : win_idx - W'(1);
                else
                    ptr <= LAST;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
